// File: rtl/code_converter_pipe_if.sv
// Valid/ready bus between the producer, the code converter and the consumer.
interface code_converter_pipe_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_mode;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_err;
  logic [1:0]       out_mode;

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_err, out_mode
  );

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_data, out_err, out_mode
  );
endinterface

// File: rtl/code_converter_pipe.sv
// Handshaked code converter: bin->Gray, iterative Gray->bin, BCD<->excess-3,
// with saturating transfer and error counters.
module code_converter_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  code_converter_pipe_if.slave  io,
  output logic [CNT_W-1:0]      conv_cnt,
  output logic [CNT_W-1:0]      err_cnt
);

  localparam int unsigned CW  = $clog2(WIDTH);
  localparam int unsigned NIB = WIDTH / 4;

  if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_bad_width
    $error("code_converter_pipe: WIDTH must be a multiple of 4 and >= 4");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_n;
  logic [CW-1:0]    cnt_q, cnt_n, cnt_up;
  logic [WIDTH-1:0] gray_q, gray_n;
  logic [WIDTH-1:0] data_q, data_n;
  logic             err_q, err_n;
  logic             valid_q, valid_n;
  logic [1:0]       mode_q, mode_n;
  logic [CNT_W-1:0] conv_q, conv_n;
  logic [CNT_W-1:0] errc_q, errc_n;

  // Per-nibble excess-3 shift; returns {err, result}.
  function automatic logic [WIDTH:0] xs3_conv(input logic [WIDTH-1:0] d,
                                               input logic to_bcd);
    logic [3:0]       n;
    logic [WIDTH-1:0] r;
    logic             e;
    r = '0;
    e = 1'b0;
    for (int i = 0; i < int'(NIB); i++) begin
      n = d[4*i +: 4];
      if (to_bcd) begin
        r[4*i +: 4] = n - 4'd3;
        e = e | (n < 4'd3) | (n > 4'd12);
      end else begin
        r[4*i +: 4] = n + 4'd3;
        e = e | (n > 4'd9);
      end
    end
    return {e, r};
  endfunction

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    gray_n  = gray_q;
    data_n  = data_q;
    err_n   = err_q;
    valid_n = valid_q;
    mode_n  = mode_q;
    conv_n  = conv_q;
    errc_n  = errc_q;
    cnt_up  = cnt_q + CW'(1);

    case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          mode_n = io.in_mode;
          case (io.in_mode)
            2'b00: begin
              data_n  = io.in_data ^ (io.in_data >> 1);
              err_n   = 1'b0;
              valid_n = 1'b1;
              state_n = DONE;
            end
            2'b01: begin
              // MSB passes straight through; lower bits resolve one per BUSY edge.
              gray_n            = io.in_data;
              data_n            = '0;
              data_n[WIDTH-1]   = io.in_data[WIDTH-1];
              err_n             = 1'b0;
              cnt_n             = CW'(WIDTH - 2);
              state_n           = BUSY;
            end
            2'b10: begin
              {err_n, data_n} = xs3_conv(io.in_data, 1'b0);
              valid_n         = 1'b1;
              state_n         = DONE;
            end
            default: begin
              {err_n, data_n} = xs3_conv(io.in_data, 1'b1);
              valid_n         = 1'b1;
              state_n         = DONE;
            end
          endcase
        end
      end
      BUSY: begin
        data_n[cnt_q] = data_q[cnt_up] ^ gray_q[cnt_q];
        cnt_n         = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          valid_n = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        if (io.out_ready) begin
          valid_n = 1'b0;
          state_n = IDLE;
          if (conv_q != '1) conv_n = conv_q + CNT_W'(1);
          if (err_q && (errc_q != '1)) errc_n = errc_q + CNT_W'(1);
        end
      end
      default: begin
        valid_n = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gray_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      mode_q  <= 2'b00;
      conv_q  <= '0;
      errc_q  <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      gray_q  <= gray_n;
      data_q  <= data_n;
      err_q   <= err_n;
      valid_q <= valid_n;
      mode_q  <= mode_n;
      conv_q  <= conv_n;
      errc_q  <= errc_n;
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = valid_q;
  assign io.out_data  = data_q;
  assign io.out_err   = err_q;
  assign io.out_mode  = mode_q;
  assign conv_cnt     = conv_q;
  assign err_cnt      = errc_q;

endmodule

// File: tb/tb_code_converter_pipe.sv
// Directed bench for code_converter_pipe; a narrow-counter twin sees the same
// traffic so counter saturation is reachable in few transfers.
module tb_code_converter_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  code_converter_pipe_if #(.WIDTH(8)) bus ();
  code_converter_pipe_if #(.WIDTH(8)) bus_s ();

  logic [15:0] conv_cnt, err_cnt;
  logic [3:0]  conv_cnt_s, err_cnt_s;
  logic [7:0]  g;

  code_converter_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .io(bus), .conv_cnt(conv_cnt), .err_cnt(err_cnt)
  );

  code_converter_pipe #(.WIDTH(8), .CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .io(bus_s), .conv_cnt(conv_cnt_s), .err_cnt(err_cnt_s)
  );

  assign bus_s.in_valid  = bus.in_valid;
  assign bus_s.in_mode   = bus.in_mode;
  assign bus_s.in_data   = bus.in_data;
  assign bus_s.out_ready = bus.out_ready;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] m, input logic [7:0] d);
    int n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("in_ready_before_send", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_mode  = m;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int max);
    int n = 0;
    while (!bus.out_valid && n < max) begin
      tick();
      n++;
    end
    chk("out_valid_wait", 32'(bus.out_valid), 1);
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_mode   = 2'b00;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_conv_cnt", 32'(conv_cnt), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    rst_n = 1'b1;
    tick();

    // bin->Gray with latency 1
    send(2'b00, 8'h2D);
    chk("b2g_valid_lat1", 32'(bus.out_valid), 1);
    chk("b2g_data", 32'(bus.out_data), 'h3B);
    chk("b2g_err", 32'(bus.out_err), 0);
    chk("b2g_mode", 32'(bus.out_mode), 0);
    take();
    chk("b2g_conv_cnt", 32'(conv_cnt), 1);
    chk("b2g_valid_drop", 32'(bus.out_valid), 0);
    chk("b2g_idle", 32'(bus.in_ready), 1);

    // Gray->bin: valid exactly 7 edges after accept, stray in_valid ignored
    send(2'b01, 8'h3B);
    for (int k = 1; k <= 7; k++) begin
      bus.in_valid = 1'b1;
      bus.in_mode  = 2'b00;
      bus.in_data  = 8'hFF;
      tick();
      chk("g2b_valid_timing", 32'(bus.out_valid), (k == 7) ? 1 : 0);
      chk("g2b_in_ready_low", 32'(bus.in_ready), 0);
    end
    bus.in_valid = 1'b0;
    chk("g2b_data", 32'(bus.out_data), 'h2D);
    chk("g2b_err", 32'(bus.out_err), 0);
    chk("g2b_mode", 32'(bus.out_mode), 1);
    take();
    chk("g2b_conv_cnt", 32'(conv_cnt), 2);

    // Round-trip sweep through both Gray directions
    for (int v = 0; v < 256; v++) begin
      send(2'b00, 8'(v));
      chk("sweep_b2g", 32'(bus.out_data), 32'(v ^ (v >> 1)));
      g = bus.out_data;
      take();
      send(2'b01, g);
      wait_valid(20);
      chk("sweep_g2b", 32'(bus.out_data), 32'(v));
      take();
    end
    chk("sweep_conv_cnt", 32'(conv_cnt), 514);
    chk("sweep_conv_cnt_sat", 32'(conv_cnt_s), 'hF);
    chk("sweep_err_cnt_sat", 32'(err_cnt_s), 0);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    // BCD->excess-3
    send(2'b10, 8'h47);
    chk("xs3_data", 32'(bus.out_data), 'h7A);
    chk("xs3_err", 32'(bus.out_err), 0);
    take();
    send(2'b10, 8'h4C);
    chk("xs3_bad_data", 32'(bus.out_data), 'h7F);
    chk("xs3_bad_err", 32'(bus.out_err), 1);
    take();
    chk("xs3_err_cnt", 32'(err_cnt), 1);
    chk("xs3_conv_cnt", 32'(conv_cnt), 2);

    // excess-3->BCD including both low and high invalid digits
    send(2'b11, 8'h7A);
    chk("bcd_data", 32'(bus.out_data), 'h47);
    chk("bcd_err", 32'(bus.out_err), 0);
    chk("bcd_mode", 32'(bus.out_mode), 3);
    take();
    send(2'b11, 8'h12);
    chk("bcd_low_data", 32'(bus.out_data), 'hEF);
    chk("bcd_low_err", 32'(bus.out_err), 1);
    take();
    send(2'b11, 8'hD5);
    chk("bcd_high_data", 32'(bus.out_data), 'hA2);
    chk("bcd_high_err", 32'(bus.out_err), 1);
    take();
    chk("bcd_err_cnt", 32'(err_cnt), 3);
    chk("bcd_conv_cnt", 32'(conv_cnt), 5);

    // out_ready while idle has no effect
    bus.out_ready = 1'b1;
    tick();
    tick();
    bus.out_ready = 1'b0;
    chk("idle_ready_conv_cnt", 32'(conv_cnt), 5);
    chk("idle_ready_valid", 32'(bus.out_valid), 0);

    // Backpressure hold
    send(2'b00, 8'h2D);
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1;
      tick();
      chk("bp_valid", 32'(bus.out_valid), 1);
      chk("bp_data", 32'(bus.out_data), 'h3B);
      chk("bp_mode", 32'(bus.out_mode), 0);
      chk("bp_in_ready", 32'(bus.in_ready), 0);
      chk("bp_conv_cnt", 32'(conv_cnt), 5);
    end
    bus.in_valid = 1'b0;
    take();
    chk("bp_release_conv_cnt", 32'(conv_cnt), 6);
    chk("bp_release_idle", 32'(bus.in_ready), 1);
    chk("bp_release_valid", 32'(bus.out_valid), 0);

    // Reset mid-BUSY discards the conversion
    send(2'b01, 8'h3B);
    tick();
    tick();
    tick();
    chk("busy_before_rst", 32'(bus.in_ready), 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_in_ready", 32'(bus.in_ready), 1);
    chk("midrst_out_valid", 32'(bus.out_valid), 0);
    chk("midrst_out_data", 32'(bus.out_data), 0);
    chk("midrst_conv_cnt", 32'(conv_cnt), 0);
    chk("midrst_err_cnt", 32'(err_cnt), 0);
    tick();
    chk("midrst_stays_idle", 32'(bus.out_valid), 0);
    send(2'b00, 8'h47);
    chk("postrst_data", 32'(bus.out_data), 'h64);
    take();
    chk("postrst_conv_cnt", 32'(conv_cnt), 1);

    // Saturation on the narrow-counter twin
    for (int k = 0; k < 14; k++) begin
      send(2'b10, 8'hAA);
      chk("sat_xs3_data", 32'(bus.out_data), 'hDD);
      take();
    end
    chk("sat_conv_at_max", 32'(conv_cnt_s), 'hF);
    chk("sat_err_below_max", 32'(err_cnt_s), 'hE);
    for (int k = 0; k < 2; k++) begin
      send(2'b10, 8'hAA);
      take();
    end
    chk("sat_conv_held", 32'(conv_cnt_s), 'hF);
    chk("sat_err_held", 32'(err_cnt_s), 'hF);
    chk("wide_conv_cnt", 32'(conv_cnt), 17);
    chk("wide_err_cnt", 32'(err_cnt), 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
